// File: rtl/dmem_pkg.sv
// Shared definitions for the core-side data-memory requester: FSM encoding,
// the request record and default parameters.
package dmem_pkg;

  localparam int unsigned DMEM_WIDTH      = 8;
  localparam int unsigned DMEM_WAIT_LIMIT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic                  we;
    logic [DMEM_WIDTH-1:0] addr;
    logic [DMEM_WIDTH-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_req_slot.sv
// One-entry request holding register with a full flag; a load in the same
// cycle as a clear replaces the entry rather than emptying it.
module dmem_req_slot
  import dmem_pkg::*;
#(
  parameter type req_t = dmem_req_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ld_i,
  input  logic clr_i,
  input  req_t d_i,
  output logic full_o,
  output req_t q_o
);

  logic full_q;
  req_t data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (ld_i) begin
      full_q <= 1'b1;
      data_q <= d_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign q_o    = data_q;

endmodule

// File: rtl/dmem_requester.sv
// Core-side initiator for the shared data-memory controller: active + pending
// request slots, ISSUE/GAP handshake with the controller, sticky wait timeout.
module dmem_requester
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH      = DMEM_WIDTH,
  parameter int unsigned WAIT_LIMIT = DMEM_WAIT_LIMIT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             busy,
  output logic             err_timeout,
  output logic             memREAD,
  output logic             memWE,
  output logic [WIDTH-1:0] AR,
  output logic [WIDTH-1:0] DR,
  input  logic [WIDTH-1:0] MEM,
  input  logic             memAV
);

  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  localparam int unsigned CW = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  dmem_state_e      state_q;
  logic             memREAD_q, memWE_q;
  logic             rsp_valid_q, busy_q, err_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic [CW-1:0]    wait_q, wait_d;

  req_t new_req, act_d, act_q, pend_q;
  logic act_full, pend_full, act_ld, act_clr, pend_ld, pend_clr;
  logic ready, accept, act_full_nxt, pend_full_nxt;

  assign new_req = {req_we, req_addr, req_wdata};
  assign ready   = !(act_full && pend_full);
  assign accept  = req_valid && ready;
  assign wait_d  = wait_q + ONE_C;

  // The completed request stays in active through GAP; GAP refills active
  // from pending first, else from a request accepted this cycle.
  always_comb begin
    act_ld   = 1'b0;
    act_clr  = 1'b0;
    pend_ld  = 1'b0;
    pend_clr = 1'b0;
    act_d    = new_req;
    case (state_q)
      IDLE:  act_ld  = accept;
      ISSUE: pend_ld = accept;
      GAP: begin
        if (pend_full) begin
          act_ld   = 1'b1;
          act_d    = pend_q;
          pend_clr = 1'b1;
        end else if (accept) begin
          act_ld = 1'b1;
        end else begin
          act_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign act_full_nxt  = act_ld  || (act_full  && !act_clr);
  assign pend_full_nxt = pend_ld || (pend_full && !pend_clr);

  dmem_req_slot #(.req_t(req_t)) u_active (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .ld_i   (act_ld),
    .clr_i  (act_clr),
    .d_i    (act_d),
    .full_o (act_full),
    .q_o    (act_q)
  );

  dmem_req_slot #(.req_t(req_t)) u_pending (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .ld_i   (pend_ld),
    .clr_i  (pend_clr),
    .d_i    (new_req),
    .full_o (pend_full),
    .q_o    (pend_q)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      memREAD_q   <= 1'b0;
      memWE_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      busy_q      <= act_full_nxt || pend_full_nxt;
      case (state_q)
        IDLE, GAP: begin
          if (act_ld) begin
            state_q   <= ISSUE;
            memREAD_q <= !act_d.we;
            memWE_q   <= act_d.we;
            wait_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (memAV) begin
            if (!act_q.we) rsp_rdata_q <= MEM;
            rsp_valid_q <= 1'b1;
            memREAD_q   <= 1'b0;
            memWE_q     <= 1'b0;
            state_q     <= GAP;
          end else if (wait_q != LIMIT_C) begin
            wait_q <= wait_d;
            if (wait_d == LIMIT_C) err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign memREAD     = memREAD_q;
  assign memWE       = memWE_q;
  assign AR          = (memREAD_q || memWE_q) ? act_q.addr  : '0;
  assign DR          = (memREAD_q || memWE_q) ? act_q.wdata : '0;

endmodule
